// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller beside ID: load-use stall, timed MDU freeze, taken-branch squash.
// Optional perf counters (stall_cycles, flush_count) under `define HAZARD_PERF_EN.
module hazard_stall_ctrl #(
    parameter int unsigned MDU_LATENCY = 4,
    parameter int unsigned CNT_W       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ifid_rs1,
    input  logic [4:0] ifid_rs2,
    input  logic       ifid_uses_rs1,
    input  logic       ifid_uses_rs2,
    input  logic [4:0] idex_rd,
    input  logic       idex_mem_read,
    input  logic       idex_mdu_op,
    input  logic       branch_taken,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       idex_hold
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    typedef enum logic [0:0] {StRun, StMduWait} state_e;

    // The first frozen cycle happens in RUN, so the wait counter covers the rest minus release.
    localparam bit MduStallEn = (MDU_LATENCY >= 2);
    localparam logic [CNT_W-1:0] CntLoad = CNT_W'((MDU_LATENCY >= 2) ? MDU_LATENCY - 2 : 0);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rs1_hit, rs2_hit, load_use;

    assign rs1_hit  = ifid_uses_rs1 && (ifid_rs1 == idex_rd);
    assign rs2_hit  = ifid_uses_rs2 && (ifid_rs2 == idex_rd);
    assign load_use = idex_mem_read && (idex_rd != 5'd0) && (rs1_hit || rs2_hit);

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        idex_hold   = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (idex_mdu_op && MduStallEn) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_hold  = 1'b1;
                        cnt_d      = CntLoad;
                        state_d    = StMduWait;
                    end
                end
                StMduWait: begin
                    // Branch/load-use cannot occur while EX holds the MDU op.
                    if (cnt_q != '0) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_hold  = 1'b1;
                        cnt_d      = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write) stall_q <= stall_q + 32'd1;
            if (ifid_flush) flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: three DUTs (MDU_LATENCY 1, 2, 4) share stimulus; a pipeline-level
// model pushes expected outputs per cycle and a monitor compares on the falling edge.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
    logic       ifid_uses_rs1, ifid_uses_rs2, idex_mem_read, idex_mdu_op, branch_taken;

    logic pcw[3], ifw[3], flh[3], bub[3], hld[3];
`ifdef HAZARD_PERF_EN
    logic [31:0] sc[3], fc[3];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hazard_stall_ctrl #(
            .MDU_LATENCY((g == 0) ? 1 : (g == 1) ? 2 : 4),
            .CNT_W      (3)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .ifid_rs1     (ifid_rs1),
            .ifid_rs2     (ifid_rs2),
            .ifid_uses_rs1(ifid_uses_rs1),
            .ifid_uses_rs2(ifid_uses_rs2),
            .idex_rd      (idex_rd),
            .idex_mem_read(idex_mem_read),
            .idex_mdu_op  (idex_mdu_op),
            .branch_taken (branch_taken),
            .pc_write     (pcw[g]),
            .ifid_write   (ifw[g]),
            .ifid_flush   (flh[g]),
            .idex_bubble  (bub[g]),
            .idex_hold    (hld[g])
`ifdef HAZARD_PERF_EN
            ,
            .stall_cycles (sc[g]),
            .flush_count  (fc[g])
`endif
        );
    end

    typedef struct packed {
        logic        pcw, ifw, flh, bub, hld;
        logic [31:0] stall, flush;
    } exp_t;
    typedef exp_t [2:0] exp3_t;

    exp3_t exp_q[$];
    int    lat[3] = '{1, 2, 4};
    int    age[3];          // EX cycles the current MDU op has spent, 0 = no op in flight
    int    s_acc[3], f_acc[3];
    int    n_cmp = 0, n_err = 0, cyc = 0;

    // Drive one cycle of inputs and push the model's expected response.
    task automatic step(input logic r, input logic br, input logic mr, input logic [4:0] rd,
                        input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                        input logic u2, input logic mdu);
        exp3_t e;
        logic  lu;
        @(posedge clk);
        #1;
        rst = r; branch_taken = br; idex_mem_read = mr; idex_rd = rd;
        ifid_rs1 = r1; ifid_rs2 = r2; ifid_uses_rs1 = u1; ifid_uses_rs2 = u2;
        idex_mdu_op = mdu;
        lu = mr && (rd != 0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
        for (int i = 0; i < 3; i++) begin
            e[i] = '{pcw: 1'b1, ifw: 1'b1, flh: 1'b0, bub: 1'b0, hld: 1'b0,
                     stall: 32'(s_acc[i]), flush: 32'(f_acc[i])};
            if (r) begin
                e[i].pcw = 0; e[i].ifw = 0; e[i].flh = 1; e[i].bub = 1;
                age[i] = 0;
            end else if (age[i] > 0) begin
                age[i]++;
                if (age[i] < lat[i]) begin
                    e[i].pcw = 0; e[i].ifw = 0; e[i].hld = 1;
                end else begin
                    age[i] = 0;
                end
            end else if (br) begin
                e[i].flh = 1; e[i].bub = 1;
            end else if (lu) begin
                e[i].pcw = 0; e[i].ifw = 0; e[i].bub = 1;
            end else if (mdu && lat[i] > 1) begin
                age[i] = 1;
                e[i].pcw = 0; e[i].ifw = 0; e[i].hld = 1;
            end
            if (r) begin
                s_acc[i] = 0; f_acc[i] = 0;
            end else begin
                if (!e[i].pcw) s_acc[i]++;
                if (e[i].flh) f_acc[i]++;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are Mealy, so a response is presented every driven cycle.
    initial begin
        exp3_t e;
        logic  ok;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                cyc++;
                for (int i = 0; i < 3; i++) begin
                    ok = (pcw[i] === e[i].pcw) && (ifw[i] === e[i].ifw) &&
                         (flh[i] === e[i].flh) && (bub[i] === e[i].bub) &&
                         (hld[i] === e[i].hld);
`ifdef HAZARD_PERF_EN
                    ok = ok && (sc[i] === e[i].stall) && (fc[i] === e[i].flush);
`endif
                    n_cmp++;
                    if (!ok) begin
                        n_err++;
                        $display("FAIL lat%0d cyc%0d: got pcw/ifw/flh/bub/hld=%b%b%b%b%b, want %b%b%b%b%b",
                                 lat[i], cyc, pcw[i], ifw[i], flh[i], bub[i], hld[i],
                                 e[i].pcw, e[i].ifw, e[i].flh, e[i].bub, e[i].hld);
`ifdef HAZARD_PERF_EN
                        $display("FAIL lat%0d cyc%0d perf: got stall=%0d flush=%0d, want %0d/%0d",
                                 lat[i], cyc, sc[i], fc[i], e[i].stall, e[i].flush);
`endif
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            age[i] = 0; s_acc[i] = 0; f_acc[i] = 0;
        end
        rst = 1; branch_taken = 0; idex_mem_read = 0; idex_rd = 0; ifid_rs1 = 0;
        ifid_rs2 = 0; ifid_uses_rs1 = 0; ifid_uses_rs2 = 0; idex_mdu_op = 0;

        // Reset, then idle release.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Load-use and its non-hazard variants.
        step(0, 0, 1, 5, 0, 5, 0, 1, 0);
        idle(1);
        step(0, 0, 1, 0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 5, 0, 5, 0, 0, 0);
        step(0, 0, 1, 5, 5, 0, 1, 0, 0);
        idle(1);
        // Branch beats load-use.
        step(0, 1, 1, 5, 0, 5, 0, 1, 0);
        idle(1);
        // MDU op held in EX.
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(3);
        // Reset during the 2nd stall cycle of the latency-4 op.
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(5);

        // Randomised traffic with a small register space to provoke hits.
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 12),
                 ($urandom_range(0, 99) < 50), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), ($urandom_range(0, 99) < 20));
        end
        idle(2);
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
